lsu_align_seq: RTL and testbench
================================

LSU_ALIGN_SEQ -- requirements
Module: lsu_align_seq

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low; ports are clk and rst (rst=0 resets).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  async active-low reset.
REQ-004 MemReqM  in  1  memory-stage access valid.
REQ-005 MemWriteM  in  1  1=store, 0=load.
REQ-006 mem_modeM  in  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; other codes are treated as no access.
REQ-007 ALUResultM  in  32  byte address.
REQ-008 WriteDataM  in  32  store data, right-justified.
REQ-009 dm_rdata  in  32  word read from data memory, combinational on dm_addr.
REQ-010 dm_addr  out  32  word-aligned address, bits[1:0]=00.
REQ-011 dm_we  out  1  data memory write enable.
REQ-012 dm_be  out  4  byte-lane enables; lane n = bits[8n+7:8n].
REQ-013 dm_wdata  out  32  lane-positioned store data.
REQ-014 ReadDataM  out  32  extended load result.
REQ-015 StallM  out  1  freeze the upstream pipeline this cycle.
REQ-016 misalign_exc  out  1  misaligned-access trap (MISALIGN_TRAP_EN only; tied 0 otherwise).

Function
REQ-017 Offset is ALUResultM[1:0]; an access is misaligned if it is a half at offset 3 or a word at offset 1-3; all bytes, halves at offsets 0-2, and words at offset 0 are aligned.
REQ-018 An aligned access completes in the request cycle: dm_addr={addr[31:2],00}; dm_be marks the touched lanes; dm_we=MemReqM&MemWriteM; StallM=0.
REQ-019 The FSM has two states, IDLE and SPLIT, and resets to IDLE.
REQ-020 A misaligned request in IDLE drives the first word access that cycle (lanes offset..3), asserts StallM=1, latches address, data, mode and the low read bytes, and goes to SPLIT.
REQ-021 In SPLIT, the block accesses word dm_addr+4 (modulo 2^32), lanes 0..(offset+size-5), using only latched values; StallM=0; the FSM returns to IDLE at the next edge.
REQ-022 Inputs during SPLIT are ignored.
REQ-023 A store writes its lower-addressed bytes in the first cycle and the remainder in the second cycle, little-endian.
REQ-024 A load assembles bytes in address order: latched first-word bytes low, dm_rdata bytes high.
REQ-025 Modes 000 and 001 sign-extend from bit 7 or 15; modes 100 and 101 zero-extend.
REQ-026 ReadDataM is valid in the cycle StallM=0 that ends the access; otherwise it is don't-care.
REQ-027 Address 0xFFFFFFFD word: first access addr 0xFFFFFFFC, second access addr 0x00000000.
REQ-028 When MemReqM=0 or the mode is invalid: dm_we=0, dm_be=0000, StallM=0.

Reset
REQ-029 While rst=0: FSM=IDLE, latches=0, dm_we=0, dm_be=0000, StallM=0, misalign_exc=0, ReadDataM=0, all applied immediately and asynchronously.
REQ-030 Reset during SPLIT aborts the second access; bytes already written by the first access are not rolled back.

Configuration
REQ-031 Macro MISALIGN_TRAP_EN defined: no SPLIT state; a misaligned request asserts misalign_exc=1 for that cycle only, with dm_we=0 and StallM=0, and ReadDataM=0.
REQ-032 Macro MISALIGN_TRAP_EN undefined: misaligned accesses are split per REQ-020 to REQ-024, and misalign_exc=0 always.

Verification (memory preload: word0=0x44332211, word1=0x88776655)
REQ-033 LW at 0 -> one cycle: dm_addr=0, StallM=0, ReadDataM=0x44332211.
REQ-034 LW at 2 -> cycle 1: dm_addr=0, StallM=1; cycle 2: dm_addr=4, StallM=0, ReadDataM=0x66554433.
REQ-035 SW 0xAABBCCDD at 1 -> cycle 1: be=1110, wdata=0xBBCCDDxx, addr 0; cycle 2: be=0001, wdata lane0=0xAA, addr 4; final contents word0=0xBBCCDD11, word1=0x887766AA.
REQ-036 LB at 7 -> 0xFFFFFF88; LBU at 7 -> 0x00000088; LH at 3 -> 0x00005544, with one stall cycle.
REQ-037 Assert rst=0 during the SPLIT cycle of a SW at 1 -> StallM=0 and dm_we=0 immediately; after release, FSM=IDLE and word1 is unchanged.
REQ-038 With MISALIGN_TRAP_EN defined: SW at 1 -> misalign_exc=1 for one cycle, dm_we=0, StallM=0, memory unchanged.

Source files
------------

// File: rtl/lsu_align_seq.sv
// lsu_align_seq: memory-stage load/store alignment unit.
// Aligned accesses finish in the request cycle. A misaligned half or word is split
// into two word accesses over two cycles, with one stall cycle for the pipeline.
// Build option: define MISALIGN_TRAP_EN to raise misalign_exc on a misaligned
// access instead of splitting it. With the macro undefined the access is split.
module lsu_align_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic [2:0]  mem_modeM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] dm_rdata,
   output logic [31:0] dm_addr,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        misalign_exc
);
   typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;     // word address of the first access
   logic [1:0]  off_q, off_d;       // byte offset of the split access
   logic [2:0]  mode_q, mode_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;   // right-justified store data
   logic [31:0] rd_q, rd_d;         // word read during the first access

   logic        split_cyc;
   logic        req_ok;
   logic        misaligned;
   logic [2:0]  act_mode;
   logic [1:0]  act_off;
   logic [4:0]  act_sh;
   logic [5:0]  inv_sh;
   logic [7:0]  lanes;              // lanes across two consecutive words

   function automatic logic mode_valid(input logic [2:0] m);
      case (m)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

   // Byte lanes touched by an access, spread over the first and second word
   function automatic logic [7:0] lane_mask(input logic [2:0] m, input logic [1:0] off);
      logic [7:0] base;
      case (m[1:0])
         2'b00:   base = 8'h01;
         2'b01:   base = 8'h03;
         default: base = 8'h0F;
      endcase
      return base << off;
   endfunction

   // Sign or zero extension of the right-justified load value
   function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] m);
      case (m)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b100:  return {24'b0, w[7:0]};
         3'b101:  return {16'b0, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Select the access context: live inputs in IDLE, latched copy in SPLIT
   always_comb begin
      split_cyc  = (state_q == SPLIT);
      act_mode   = split_cyc ? mode_q : mem_modeM;
      act_off    = split_cyc ? off_q : ALUResultM[1:0];
      act_sh     = {act_off, 3'b000};
      inv_sh     = 6'd32 - {1'b0, act_sh};
      lanes      = lane_mask(act_mode, act_off);
      req_ok     = MemReqM & mode_valid(mem_modeM);
      misaligned = req_ok & (|lanes[7:4]);
   end

   // Memory port, load result and next-state logic for the current cycle
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      off_d        = off_q;
      mode_d       = mode_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      rd_d         = rd_q;
      dm_addr      = {ALUResultM[31:2], 2'b00};
      dm_we        = 1'b0;
      dm_be        = 4'b0000;
      dm_wdata     = WriteDataM << act_sh;
      ReadDataM    = 32'b0;
      StallM       = 1'b0;
      misalign_exc = 1'b0;
      if (split_cyc) begin
         // Second word: upper lanes only, driven purely from latched state
         dm_addr   = addr_q + 32'd4;
         dm_we     = we_q;
         dm_be     = lanes[7:4];
         dm_wdata  = wdata_q >> inv_sh;
         ReadDataM = extend((rd_q >> act_sh) | (dm_rdata << inv_sh), mode_q);
         state_d   = IDLE;
      end else if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
         misalign_exc = 1'b1;
`else
         // First word: lower-addressed bytes now, remainder next cycle
         dm_we   = MemWriteM;
         dm_be   = lanes[3:0];
         StallM  = 1'b1;
         state_d = SPLIT;
         addr_d  = {ALUResultM[31:2], 2'b00};
         off_d   = ALUResultM[1:0];
         mode_d  = mem_modeM;
         we_d    = MemWriteM;
         wdata_d = WriteDataM;
         rd_d    = dm_rdata;
`endif
      end else if (req_ok) begin
         dm_we     = MemWriteM;
         dm_be     = lanes[3:0];
         ReadDataM = extend(dm_rdata >> act_sh, mem_modeM);
      end
      // Reset quiets the port immediately, before any clock edge
      if (!rst) begin
         dm_we        = 1'b0;
         dm_be        = 4'b0000;
         StallM       = 1'b0;
         misalign_exc = 1'b0;
         ReadDataM    = 32'b0;
      end
   end

   // State and split-context registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         off_q   <= '0;
         mode_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         mode_q  <= mode_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
      end
   end
endmodule

// File: tb/tb_lsu_align_seq.sv
// tb_lsu_align_seq: bench for lsu_align_seq with a 64-byte data memory model
// (addresses alias modulo 64) and a byte-level reference memory.
module tb_lsu_align_seq;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        MemReqM;
   logic        MemWriteM;
   logic [2:0]  mem_modeM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] dm_rdata;
   logic [31:0] dm_addr;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic [31:0] ReadDataM;
   logic        StallM;
   logic        misalign_exc;

   logic [31:0] mem      [0:15];
   logic [31:0] init_mem [0:15];
   logic        load_now;
   logic [7:0]  ref_mem  [0:63];

   int checks;
   int errors;

   lsu_align_seq dut (
      .clk          (clk),
      .rst          (rst),
      .MemReqM      (MemReqM),
      .MemWriteM    (MemWriteM),
      .mem_modeM    (mem_modeM),
      .ALUResultM   (ALUResultM),
      .WriteDataM   (WriteDataM),
      .dm_rdata     (dm_rdata),
      .dm_addr      (dm_addr),
      .dm_we        (dm_we),
      .dm_be        (dm_be),
      .dm_wdata     (dm_wdata),
      .ReadDataM    (ReadDataM),
      .StallM       (StallM),
      .misalign_exc (misalign_exc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dm_rdata = mem[dm_addr[5:2]];

   always @(posedge clk) begin
      if (load_now) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
      end else if (dm_we) begin
         for (int b = 0; b < 4; b++)
            if (dm_be[b]) mem[dm_addr[5:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
   end

   task automatic preload();
      init_mem[0] = 32'h44332211;
      init_mem[1] = 32'h88776655;
      for (int i = 2; i < 16; i++) init_mem[i] = $urandom;
      for (int i = 0; i < 16; i++)
         for (int b = 0; b < 4; b++) ref_mem[4*i+b] = init_mem[i][8*b +: 8];
      load_now = 1'b1;
      @(posedge clk);
      #1 load_now = 1'b0;
   endtask

   task automatic verify_memory(input string tag);
      logic [31:0] exp;
      for (int w = 0; w < 16; w++) begin
         exp = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
         checks++;
         if (mem[w] !== exp) begin
            errors++;
            $display("FAIL %s mem[%0d]: got %08h want %08h", tag, w, mem[w], exp);
         end
      end
   endtask

   // One access: expectations come from byte addresses in the reference memory
   task automatic run_access(input logic req, input logic wr, input logic [2:0] mode,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input string tag, output logic [31:0] rd);
      int          size;
      int          lane;
      bit          valid, mis, trap, do_wr;
      logic [31:0] base, ba, exp_wd1, exp_wd2, exp_rd, m1, m2;
      logic [3:0]  exp_be1, exp_be2;
      valid = req && (mode == 3'd0 || mode == 3'd1 || mode == 3'd2 ||
                      mode == 3'd4 || mode == 3'd5);
      size  = (mode[1:0] == 2'd0) ? 1 : (mode[1:0] == 2'd1) ? 2 : 4;
      mis   = valid && ((addr % 4) + size > 4);
      trap  = mis && TRAP;
      do_wr = valid && wr && !trap;
      base  = addr & ~32'd3;
      exp_be1 = '0; exp_be2 = '0; exp_wd1 = '0; exp_wd2 = '0; exp_rd = '0;
      m1 = '0; m2 = '0;
      for (int i = 0; i < size; i++) begin
         ba   = addr + i;
         lane = int'(ba[1:0]);
         exp_rd[8*i +: 8] = ref_mem[ba[5:0]];
         if (ba[31:2] == addr[31:2]) begin
            exp_be1[lane] = 1'b1; m1[8*lane +: 8] = 8'hFF;
            exp_wd1[8*lane +: 8] = wd[8*i +: 8];
         end else begin
            exp_be2[lane] = 1'b1; m2[8*lane +: 8] = 8'hFF;
            exp_wd2[8*lane +: 8] = wd[8*i +: 8];
         end
      end
      if (!mode[2] && size < 4 && exp_rd[8*size-1])
         for (int j = 8*size; j < 32; j++) exp_rd[j] = 1'b1;
      if (!valid || trap) exp_be1 = '0;
      rd = 'x;

      @(negedge clk);
      MemReqM = req; MemWriteM = wr; mem_modeM = mode; ALUResultM = addr; WriteDataM = wd;
      #2;
      if (valid) begin
         checks++;
         if (dm_addr !== base) begin
            errors++; $display("FAIL %s addr1: got %08h want %08h", tag, dm_addr, base);
         end
      end
      checks++;
      if (StallM !== (mis && !TRAP)) begin
         errors++; $display("FAIL %s stall1: got %0b want %0b", tag, StallM, mis && !TRAP);
      end
      checks++;
      if (dm_we !== do_wr) begin
         errors++; $display("FAIL %s we1: got %0b want %0b", tag, dm_we, do_wr);
      end
      checks++;
      if (dm_be !== exp_be1) begin
         errors++; $display("FAIL %s be1: got %04b want %04b", tag, dm_be, exp_be1);
      end
      if (do_wr) begin
         checks++;
         if ((dm_wdata & m1) !== exp_wd1) begin
            errors++; $display("FAIL %s wdata1: got %08h want %08h", tag, dm_wdata & m1, exp_wd1);
         end
      end
      checks++;
      if (misalign_exc !== trap) begin
         errors++; $display("FAIL %s exc: got %0b want %0b", tag, misalign_exc, trap);
      end
      if (trap) begin
         checks++;
         if (ReadDataM !== 32'h0) begin
            errors++; $display("FAIL %s trap_rdata: got %08h want 00000000", tag, ReadDataM);
         end
      end
      if (valid && !wr && !mis) begin
         rd = ReadDataM;
         checks++;
         if (ReadDataM !== exp_rd) begin
            errors++; $display("FAIL %s rdata: got %08h want %08h", tag, ReadDataM, exp_rd);
         end
      end
      if (mis && !TRAP) begin
         @(negedge clk);
         // Inputs during the second cycle must have no effect
         MemReqM = 1'($urandom); MemWriteM = 1'($urandom); mem_modeM = 3'($urandom);
         ALUResultM = $urandom; WriteDataM = $urandom;
         #2;
         checks++;
         if (dm_addr !== base + 32'd4) begin
            errors++; $display("FAIL %s addr2: got %08h want %08h", tag, dm_addr, base + 32'd4);
         end
         checks++;
         if (StallM !== 1'b0) begin
            errors++; $display("FAIL %s stall2: got %0b want 0", tag, StallM);
         end
         checks++;
         if (dm_we !== wr) begin
            errors++; $display("FAIL %s we2: got %0b want %0b", tag, dm_we, wr);
         end
         checks++;
         if (dm_be !== exp_be2) begin
            errors++; $display("FAIL %s be2: got %04b want %04b", tag, dm_be, exp_be2);
         end
         if (wr) begin
            checks++;
            if ((dm_wdata & m2) !== exp_wd2) begin
               errors++; $display("FAIL %s wdata2: got %08h want %08h", tag, dm_wdata & m2, exp_wd2);
            end
         end else begin
            rd = ReadDataM;
            checks++;
            if (ReadDataM !== exp_rd) begin
               errors++; $display("FAIL %s rdata2: got %08h want %08h", tag, ReadDataM, exp_rd);
            end
         end
      end
      @(posedge clk);
      #1 MemReqM = 1'b0;
      if (do_wr)
         for (int i = 0; i < size; i++) begin
            ba = addr + i;
            ref_mem[ba[5:0]] = wd[8*i +: 8];
         end
      $display("%s: req=%0b we=%0b mode=%0d addr=%08h wd=%08h split=%0b rd=%08h",
               tag, req, wr, mode, addr, wd, mis && !TRAP, rd);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      preload();
      MemReqM = 1'b1; MemWriteM = 1'b1; mem_modeM = 3'b010;
      ALUResultM = 32'h1; WriteDataM = 32'hDEADBEEF;
      #1;
      checks++;
      if (dm_we !== 1'b0) begin errors++; $display("FAIL reset we: got %0b want 0", dm_we); end
      checks++;
      if (dm_be !== 4'b0) begin errors++; $display("FAIL reset be: got %04b want 0000", dm_be); end
      checks++;
      if (StallM !== 1'b0) begin errors++; $display("FAIL reset stall: got %0b want 0", StallM); end
      checks++;
      if (misalign_exc !== 1'b0) begin errors++; $display("FAIL reset exc: got %0b want 0", misalign_exc); end
      checks++;
      if (ReadDataM !== 32'h0) begin errors++; $display("FAIL reset rdata: got %08h want 0", ReadDataM); end
      @(negedge clk);
      MemReqM = 1'b0;
      rst = 1'b1;
      verify_memory("reset");
   endtask

`ifndef MISALIGN_TRAP_EN
   task automatic test_directed();
      logic [31:0] rd;
      preload();
      run_access(1, 0, 3'b010, 32'd0, 32'd0, "LW@0", rd);
      checks++;
      if (rd !== 32'h44332211) begin errors++; $display("FAIL LW@0: got %08h want 44332211", rd); end
      run_access(1, 0, 3'b010, 32'd2, 32'd0, "LW@2", rd);
      checks++;
      if (rd !== 32'h66554433) begin errors++; $display("FAIL LW@2: got %08h want 66554433", rd); end
      run_access(1, 0, 3'b000, 32'd7, 32'd0, "LB@7", rd);
      checks++;
      if (rd !== 32'hFFFFFF88) begin errors++; $display("FAIL LB@7: got %08h want FFFFFF88", rd); end
      run_access(1, 0, 3'b100, 32'd7, 32'd0, "LBU@7", rd);
      checks++;
      if (rd !== 32'h00000088) begin errors++; $display("FAIL LBU@7: got %08h want 00000088", rd); end
      run_access(1, 0, 3'b001, 32'd3, 32'd0, "LH@3", rd);
      checks++;
      if (rd !== 32'h00005544) begin errors++; $display("FAIL LH@3: got %08h want 00005544", rd); end
      run_access(1, 1, 3'b010, 32'd1, 32'hAABBCCDD, "SW@1", rd);
      checks++;
      if (mem[0] !== 32'hBBCCDD11) begin errors++; $display("FAIL SW@1 word0: got %08h want BBCCDD11", mem[0]); end
      checks++;
      if (mem[1] !== 32'h887766AA) begin errors++; $display("FAIL SW@1 word1: got %08h want 887766AA", mem[1]); end
      verify_memory("directed");
   endtask

   task automatic test_split_reset();
      logic [31:0] rd, w1_exp;
      w1_exp = {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]};
      @(negedge clk);
      MemReqM = 1'b1; MemWriteM = 1'b1; mem_modeM = 3'b010;
      ALUResultM = 32'd1; WriteDataM = 32'h01020304;
      #2;
      checks++;
      if (StallM !== 1'b1) begin errors++; $display("FAIL split_reset stall1: got %0b want 1", StallM); end
      @(negedge clk);
      MemReqM = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (StallM !== 1'b0) begin errors++; $display("FAIL split_reset stall: got %0b want 0", StallM); end
      checks++;
      if (dm_we !== 1'b0) begin errors++; $display("FAIL split_reset we: got %0b want 0", dm_we); end
      checks++;
      if (dm_be !== 4'b0) begin errors++; $display("FAIL split_reset be: got %04b want 0000", dm_be); end
      @(negedge clk);
      rst = 1'b1;
      ref_mem[1] = 8'h04; ref_mem[2] = 8'h03; ref_mem[3] = 8'h02;
      checks++;
      if (mem[1] !== w1_exp) begin errors++; $display("FAIL split_reset word1: got %08h want %08h", mem[1], w1_exp); end
      verify_memory("split_reset");
      $display("split_reset: SW@1 aborted in second cycle");
      run_access(1, 0, 3'b010, 32'd0, 32'd0, "LW@0 after reset", rd);
      checks++;
      if (rd !== {24'h020304, ref_mem[0]}) begin
         errors++; $display("FAIL split_reset reload: got %08h want %08h", rd, {24'h020304, ref_mem[0]});
      end
   endtask
`else
   task automatic test_trap();
      logic [31:0] rd;
      preload();
      run_access(1, 1, 3'b010, 32'd1, 32'hAABBCCDD, "SW@1 trap", rd);
      checks++;
      if (mem[0] !== 32'h44332211) begin errors++; $display("FAIL trap word0: got %08h want 44332211", mem[0]); end
      checks++;
      if (mem[1] !== 32'h88776655) begin errors++; $display("FAIL trap word1: got %08h want 88776655", mem[1]); end
   endtask
`endif

   task automatic test_invalid();
      logic [31:0] rd;
      run_access(1, 1, 3'b011, 32'h8, $urandom, "mode3", rd);
      run_access(1, 1, 3'b110, 32'h9, $urandom, "mode6", rd);
      run_access(1, 1, 3'b111, 32'hB, $urandom, "mode7", rd);
      run_access(0, 1, 3'b010, 32'hD, $urandom, "noreq store", rd);
      run_access(0, 0, 3'b001, 32'hF, $urandom, "noreq load", rd);
      verify_memory("invalid");
   endtask

   task automatic test_wrap();
      logic [31:0] rd;
      run_access(1, 0, 3'b010, 32'hFFFFFFFD, 32'd0, "LW@FFFFFFFD", rd);
      run_access(1, 1, 3'b010, 32'hFFFFFFFE, 32'hC0FFEE42, "SW@FFFFFFFE", rd);
      run_access(1, 0, 3'b010, 32'hFFFFFFFE, 32'd0, "LW@FFFFFFFE", rd);
      run_access(1, 0, 3'b001, 32'hFFFFFFFF, 32'd0, "LH@FFFFFFFF", rd);
      verify_memory("wrap");
   endtask

   task automatic test_random();
      logic [31:0] rd;
      for (int n = 0; n < 300; n++)
         run_access(($urandom_range(0, 7) != 0), 1'($urandom), 3'($urandom_range(0, 7)),
                    $urandom, $urandom, "rand", rd);
      verify_memory("random");
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0; load_now = 1'b0;
      MemReqM = 1'b0; MemWriteM = 1'b0; mem_modeM = 3'b0;
      ALUResultM = '0; WriteDataM = '0;
      test_reset();
`ifndef MISALIGN_TRAP_EN
      test_directed();
      test_split_reset();
`else
      test_trap();
`endif
      test_invalid();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
